// File: rtl/mcp_tx_scheduler_if.sv
// Bundle between the requesters/UART transmitter and the TX scheduler.
// The requester side carries level requests with their register-map fields
// and receives the per-requester ack; the UART side carries the packet,
// its load strobe and the transmitter busy flag.
interface mcp_tx_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_op;
    logic [8*NUM_REQ-1:0] req_chip_id;
    logic [8*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic [WIDTH-1:0]     tx_data;
    logic                 ld_tx_data;
    logic                 tx_busy;

    // Requesters plus the UART transmitter: drive requests and busy, observe results.
    modport master (
        output req, req_op, req_chip_id, req_addr, req_data, tx_busy,
        input  ack, tx_data, ld_tx_data
    );

    // The scheduler itself.
    modport slave (
        input  req, req_op, req_chip_id, req_addr, req_data, tx_busy,
        output ack, tx_data, ld_tx_data
    );
endinterface

// File: rtl/mcp_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ
// configuration requesters. A granted request is packed into a 64-bit
// packet (declare, chip id, address, data, odd parity), handed to the UART
// with a one-cycle load strobe, and acknowledged once the UART drops busy.
// If the UART never reports busy within BUSY_TIMEOUT cycles the transfer is
// abandoned, a sticky error is raised and the requester is served again
// later in round-robin order.
module mcp_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 64,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    mcp_tx_scheduler_if.slave   bus,
    output logic                sched_busy,
    output logic                timeout_err,
    output logic [15:0]         pkt_count
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);
    localparam logic [CW-1:0] TO_MAX    = CW'(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // Packet layout: [1:0] declare, [9:2] chip, [17:10] addr, [25:18] data,
    // zero fill, [63] makes the total count of ones odd.
    function automatic logic [63:0] build_pkt(input logic       op,
                                              input logic [7:0] chip,
                                              input logic [7:0] addr,
                                              input logic [7:0] data);
        logic [63:0] p;
        p         = 64'd0;
        p[1:0]    = {1'b1, op};
        p[9:2]    = chip;
        p[17:10]  = addr;
        p[25:18]  = data;
        p[63]     = ~(^p[62:0]);
        return p;
    endfunction

    state_t             state_r, next_state_s;
    logic [GW-1:0]      last_grant_r, last_grant_nxt_s;
    logic [GW-1:0]      grant_r, grant_nxt_s;
    logic [WIDTH-1:0]   tx_data_r, tx_data_nxt_s;
    logic               ld_r, ld_nxt_s;
    logic [NUM_REQ-1:0] ack_r, ack_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               terr_r, terr_nxt_s;
    logic [15:0]        pkt_cnt_r, pkt_cnt_nxt_s;
    logic [CW-1:0]      cnt_r, cnt_nxt_s, cnt_inc_s;

    logic [NUM_REQ-1:0] elig_s;
    logic               found_s;
    logic [GW-1:0]      grant_idx_s;
    logic               sel_op_s;
    logic [7:0]         sel_chip_s, sel_addr_s, sel_data_s;
    logic [63:0]        pkt_s;

    // Round-robin search upward from the requester after the last grant; the
    // requester acked this cycle is masked because it still holds req until it sees ack.
    always_comb begin
        int cand;
        cand        = 0;
        elig_s      = bus.req & ~ack_r;
        found_s     = 1'b0;
        grant_idx_s = last_grant_r;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant_r) + k) % NUM_REQ;
            if (!found_s && elig_s[GW'(cand)]) begin
                found_s     = 1'b1;
                grant_idx_s = GW'(cand);
            end else begin
                found_s     = found_s;
            end
        end
    end

    // Select the candidate requester's fields for packing.
    always_comb begin
        sel_op_s   = 1'b0;
        sel_chip_s = 8'd0;
        sel_addr_s = 8'd0;
        sel_data_s = 8'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == grant_idx_s) begin
                sel_op_s   = bus.req_op[i];
                sel_chip_s = bus.req_chip_id[8*i +: 8];
                sel_addr_s = bus.req_addr[8*i +: 8];
                sel_data_s = bus.req_data[8*i +: 8];
            end else begin
                sel_op_s   = sel_op_s;
            end
        end
    end

    assign pkt_s = build_pkt(sel_op_s, sel_chip_s, sel_addr_s, sel_data_s);

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        next_state_s     = state_r;
        last_grant_nxt_s = last_grant_r;
        grant_nxt_s      = grant_r;
        tx_data_nxt_s    = tx_data_r;
        ack_nxt_s        = {NUM_REQ{1'b0}};
        terr_nxt_s       = terr_r;
        pkt_cnt_nxt_s    = pkt_cnt_r;
        cnt_nxt_s        = cnt_r;

        if (cnt_r == TO_MAX) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + CW'(1);
        end

        case (state_r)
            IDLE: begin
                if (found_s) begin
                    next_state_s     = LOAD;
                    last_grant_nxt_s = grant_idx_s;
                    grant_nxt_s      = grant_idx_s;
                    tx_data_nxt_s    = WIDTH'(pkt_s);
                end else begin
                    next_state_s     = IDLE;
                end
            end
            LOAD: begin
                cnt_nxt_s    = {CW{1'b0}};
                next_state_s = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    next_state_s = WAIT_DONE;
                end else if (cnt_inc_s == TO_MAX) begin
                    cnt_nxt_s    = cnt_inc_s;
                    terr_nxt_s   = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    cnt_nxt_s    = cnt_inc_s;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    ack_nxt_s     = NUM_REQ'(1'b1) << grant_r;
                    pkt_cnt_nxt_s = pkt_cnt_r + 16'd1;
                    next_state_s  = IDLE;
                end else begin
                    next_state_s  = WAIT_DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase

        ld_nxt_s   = (next_state_s == LOAD);
        busy_nxt_s = (next_state_s != IDLE);
    end

    // State and registered outputs; reset abandons any transfer without an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= LAST_INIT;
            grant_r      <= {GW{1'b0}};
            tx_data_r    <= {WIDTH{1'b0}};
            ld_r         <= 1'b0;
            ack_r        <= {NUM_REQ{1'b0}};
            busy_r       <= 1'b0;
            terr_r       <= 1'b0;
            pkt_cnt_r    <= 16'd0;
            cnt_r        <= {CW{1'b0}};
        end else begin
            state_r      <= next_state_s;
            last_grant_r <= last_grant_nxt_s;
            grant_r      <= grant_nxt_s;
            tx_data_r    <= tx_data_nxt_s;
            ld_r         <= ld_nxt_s;
            ack_r        <= ack_nxt_s;
            busy_r       <= busy_nxt_s;
            terr_r       <= terr_nxt_s;
            pkt_cnt_r    <= pkt_cnt_nxt_s;
            cnt_r        <= cnt_nxt_s;
        end
    end

    assign bus.tx_data    = tx_data_r;
    assign bus.ld_tx_data = ld_r;
    assign bus.ack        = ack_r;
    assign sched_busy     = busy_r;
    assign timeout_err    = terr_r;
    assign pkt_count      = pkt_cnt_r;
endmodule

// File: doc/mcp_tx_scheduler.md
MCP_TX_SCHEDULER -- requirements
Module: mcp_tx_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the FPGA UART TX.
REQ-002 Parameter WIDTH, default 64: UART packet width.
REQ-003 Parameter BUSY_TIMEOUT, default 16: cycles allowed from ld_tx_data until tx_busy asserts.
REQ-004 Port clk, input, 1: single clock, the UART tx clock (clk_tx); all logic on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port req, input, NUM_REQ: per-requester transfer request, level, held until ack.
REQ-007 Port req_op, input, NUM_REQ: per-requester op; 0 = config write (declare 2'b10), 1 = config read (declare 2'b11).
REQ-008 Port req_chip_id, input, 8*NUM_REQ: target chip ID per requester, requester i in bits [8i+7:8i].
REQ-009 Port req_addr, input, 8*NUM_REQ: register map address per requester.
REQ-010 Port req_data, input, 8*NUM_REQ: register map data per requester; ignored but still packed for reads.
REQ-011 Port ack, output, NUM_REQ: one-cycle pulse to the granted requester when its packet has fully shifted out.
REQ-012 Port tx_data, output, WIDTH: packet to uart_tx.
REQ-013 Port ld_tx_data, output, 1: load strobe to uart_tx.
REQ-014 Port tx_busy, input, 1: busy flag from uart_tx.
REQ-015 Port sched_busy, output, 1: high in every state except IDLE.
REQ-016 Port timeout_err, output, 1: sticky; set on a busy timeout.
REQ-017 Port pkt_count, output, 16: count of acked packets.

Function
REQ-018 Packet format: [1:0] declare; [9:2] chip_id; [17:10] addr; [25:18] data; [62:26] zero; [63] odd parity, so that bits [63:0] contain an odd number of ones.
REQ-019 States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-020 IDLE with any req high: grant round-robin, searching upward from (last_grant+1) mod NUM_REQ; latch the granted fields into tx_data; go to LOAD.
REQ-021 After reset, last_grant = NUM_REQ-1, so requester 0 has first priority.
REQ-022 LOAD: ld_tx_data = 1 for exactly this one cycle; clear the timeout counter; go to WAIT_BUSY.
REQ-023 WAIT_BUSY, tx_busy = 1: go to WAIT_DONE.
REQ-024 WAIT_BUSY, counter reaches BUSY_TIMEOUT: set timeout_err; no ack; no pkt_count change; last_grant still advances; go to IDLE.
REQ-025 A timed-out requester still has req high and is regranted in round-robin order.
REQ-026 WAIT_DONE, tx_busy = 0: pulse ack[grant] for one cycle; increment pkt_count with wrap at 16'hFFFF -> 0; go to IDLE.
REQ-027 Minimum request-to-request spacing: IDLE grants on the cycle after the ack cycle, with no extra idle cycle.
REQ-028 tx_data holds its value from the latch through the ack cycle; it is updated only on a grant.
REQ-029 If req drops mid-transfer, the transfer still completes and ack still pulses.
REQ-030 Requester fields are sampled only at grant; later changes are ignored.
REQ-031 Simultaneous requests are served one per transfer in rotating order; none is starved.
REQ-032 Width rules: grant index is $clog2(NUM_REQ) bits; timeout counter is $clog2(BUSY_TIMEOUT+1) bits and saturates.

Reset
REQ-033 Reset (synchronous, active-high) forces: state IDLE, ld_tx_data 0, ack 0, tx_data 0, sched_busy 0, timeout_err 0, pkt_count 0, last_grant NUM_REQ-1, counter 0.
REQ-034 Reset mid-transfer abandons the packet with no ack; uart_tx is reset separately.

Verification
REQ-035 Single write: req[0] = 1, chip 8'h10, addr 8'h05, data 8'hA5, op 0 -> ld_tx_data one cycle after grant; tx_data[25:0] = {A5,05,10,2'b10}; bit63 set for odd parity; ack[0] after tx_busy falls; pkt_count = 1.
REQ-036 All four requesters held high from reset -> grant order 0,1,2,3,0; each ack is a single pulse; tx_data never changes while tx_busy = 1.
REQ-037 Read op: req_op[2] = 1, chip 8'hFF broadcast, addr 8'h10 -> declare 2'b11; data field packed; parity bit correct.
REQ-038 tx_busy tied 0 -> timeout_err set BUSY_TIMEOUT cycles after the ld_tx_data cycle; no ack; the same request is regranted.
REQ-039 Assert reset during WAIT_DONE -> next cycle all outputs at reset values; no ack; a request after reset is granted to requester 0 first.
REQ-040 65536 acked packets -> pkt_count wraps to 0.
